// File: rtl/kme_ob_frame_monitor.sv
// Outbound KME stream frame monitor: tracks SoT/MoT/EoT framing, counts completed
// frames by type and byte length, and raises sticky protocol/watchdog error flags.
module kme_ob_frame_monitor #(
    parameter int WDOG_LIMIT = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kme_ob_tvalid,
    input  logic [63:0] kme_ob_tdata,
    input  logic [7:0]  kme_ob_tstrb,
    input  logic [7:0]  kme_ob_tuser,
    input  logic        kme_ob_tlast,
    input  logic        stall,
    input  logic        clr,
    output logic        kme_ob_tready,
    output logic [15:0] frame_cnt,
    output logic [15:0] cqe_cnt,
    output logic [15:0] stats_cnt,
    output logic [19:0] last_frame_bytes,
    output logic        frame_done,
    output logic [5:0]  err_flags
);

    localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

    localparam logic [7:0] TUSER_SOT = 8'h01;
    localparam logic [7:0] TUSER_EOT = 8'h02;
    localparam logic [7:0] TUSER_MOT = 8'h03;

    typedef enum logic [0:0] {
        IDLE,
        IN_FRAME
    } state_t;

    typedef enum logic [1:0] {
        FT_DATA,
        FT_CQE,
        FT_STATS
    } ftype_t;

    state_t              state_q, state_d;
    ftype_t              type_q, type_d;
    logic [15:0]         beat_q, beat_d;
    logic [19:0]         byte_q, byte_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;

    logic                accept;
    logic                is_sot, is_eot, is_mot, legal;
    logic [3:0]          pop;
    logic                strb_ok;
    logic [5:0]          err_set;
    logic                done_d;
    logic [19:0]         done_bytes;
    ftype_t              done_type;
    logic [7:0]          strb_inc;

    // Only the type byte of the SoT payload is inspected.
    logic unused_tdata;
    assign unused_tdata = ^kme_ob_tdata[63:8];

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : a + 16'd1;
    endfunction

    function automatic logic [19:0] sat_add20(input logic [19:0] a, input logic [3:0] b);
        logic [20:0] s;
        s = {1'b0, a} + {17'd0, b};
        return s[20] ? 20'hFFFFF : s[19:0];
    endfunction

    function automatic ftype_t decode_type(input logic [7:0] t);
        case (t)
            8'h09:   return FT_CQE;
            8'h08:   return FT_STATS;
            default: return FT_DATA;
        endcase
    endfunction

    assign accept   = kme_ob_tvalid & kme_ob_tready;
    assign is_sot   = (kme_ob_tuser == TUSER_SOT);
    assign is_eot   = (kme_ob_tuser == TUSER_EOT);
    assign is_mot   = (kme_ob_tuser == TUSER_MOT);
    assign legal    = is_sot | is_eot | is_mot;
    assign pop      = popcount8(kme_ob_tstrb);
    assign strb_inc = kme_ob_tstrb + 8'd1;

    // EoT strobes must be a nonzero run of ones starting at byte 0.
    assign strb_ok = is_eot ? ((kme_ob_tstrb != 8'h00) && ((strb_inc & kme_ob_tstrb) == 8'h00))
                            : (kme_ob_tstrb == 8'hFF);

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        beat_d     = beat_q;
        byte_d     = byte_q;
        wdog_d     = '0;
        err_set    = '0;
        done_d     = 1'b0;
        done_bytes = '0;
        done_type  = type_q;

        if (accept) begin
            if (!legal) begin
                err_set[3] = 1'b1;
            end else begin
                if (kme_ob_tlast != is_eot) err_set[2] = 1'b1;
                if (!strb_ok)               err_set[4] = 1'b1;

                if (is_sot) begin
                    if (state_q == IN_FRAME) err_set[1] = 1'b1;
                    state_d = IN_FRAME;
                    type_d  = decode_type(kme_ob_tdata[7:0]);
                    beat_d  = 16'd1;
                    byte_d  = {16'd0, pop};
                end else if (state_q == IDLE) begin
                    err_set[0] = 1'b1;
                end else if (is_mot) begin
                    beat_d = sat_inc16(beat_q);
                    byte_d = sat_add20(byte_q, pop);
                end else begin
                    done_d     = 1'b1;
                    done_bytes = sat_add20(byte_q, pop);
                    state_d    = IDLE;
                    beat_d     = '0;
                    byte_d     = '0;
                end
            end
        end else if (state_q == IN_FRAME) begin
            // Expiry lands on the cycle the idle count reaches WDOG_LIMIT.
            if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
                err_set[5] = 1'b1;
                state_d    = IDLE;
                beat_d     = '0;
                byte_d     = '0;
            end else begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            type_q           <= FT_DATA;
            beat_q           <= '0;
            byte_q           <= '0;
            wdog_q           <= '0;
            kme_ob_tready    <= 1'b0;
            frame_done       <= 1'b0;
            frame_cnt        <= '0;
            cqe_cnt          <= '0;
            stats_cnt        <= '0;
            last_frame_bytes <= '0;
            err_flags        <= '0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            beat_q        <= beat_d;
            byte_q        <= byte_d;
            wdog_q        <= wdog_d;
            kme_ob_tready <= ~stall;
            frame_done    <= done_d;

            // clr wins over any same-cycle increment or error set.
            if (clr) begin
                frame_cnt        <= '0;
                cqe_cnt          <= '0;
                stats_cnt        <= '0;
                last_frame_bytes <= '0;
                err_flags        <= '0;
            end else begin
                err_flags <= err_flags | err_set;
                if (done_d) begin
                    frame_cnt        <= sat_inc16(frame_cnt);
                    last_frame_bytes <= done_bytes;
                    if (done_type == FT_CQE)   cqe_cnt   <= sat_inc16(cqe_cnt);
                    if (done_type == FT_STATS) stats_cnt <= sat_inc16(stats_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_kme_ob_frame_monitor.sv
// Scoreboard bench for kme_ob_frame_monitor: stimulus queues expected frame
// completions and status snapshots; a monitor compares them against the DUT.
module tb_kme_ob_frame_monitor;

    localparam int WDOG = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kme_ob_tvalid = 1'b0;
    logic [63:0] kme_ob_tdata = '0;
    logic [7:0]  kme_ob_tstrb = '0;
    logic [7:0]  kme_ob_tuser = '0;
    logic        kme_ob_tlast = 1'b0;
    logic        stall = 1'b1;
    logic        clr = 1'b0;
    logic        kme_ob_tready;
    logic [15:0] frame_cnt, cqe_cnt, stats_cnt;
    logic [19:0] last_frame_bytes;
    logic        frame_done;
    logic [5:0]  err_flags;

    logic        stall_tgl = 1'b0;
    logic        snap_req = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    typedef struct {
        logic [5:0]  err;
        logic [15:0] fc;
        logic [15:0] cc;
        logic [15:0] sc;
        logic [19:0] lfb;
        logic        rdy;
        logic        chk_rdy;
    } exp_t;

    exp_t done_q[$];
    exp_t snap_q[$];

    kme_ob_frame_monitor #(.WDOG_LIMIT(WDOG)) dut (
        .clk              (clk),
        .rst              (rst),
        .kme_ob_tvalid    (kme_ob_tvalid),
        .kme_ob_tdata     (kme_ob_tdata),
        .kme_ob_tstrb     (kme_ob_tstrb),
        .kme_ob_tuser     (kme_ob_tuser),
        .kme_ob_tlast     (kme_ob_tlast),
        .stall            (stall),
        .clr              (clr),
        .kme_ob_tready    (kme_ob_tready),
        .frame_cnt        (frame_cnt),
        .cqe_cnt          (cqe_cnt),
        .stats_cnt        (stats_cnt),
        .last_frame_bytes (last_frame_bytes),
        .frame_done       (frame_done),
        .err_flags        (err_flags)
    );

    always #5 clk = ~clk;

    // stall either toggles every cycle or is held low once stimulus is running
    initial begin
        forever begin
            @(negedge clk);
            if (stall_tgl) stall = ~stall;
            else if (!rst) stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Monitor: sample one time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_frame_done actual=1 required=0");
                end else begin
                    e = done_q.pop_front();
                    chk("done_frame_cnt", 32'(frame_cnt), 32'(e.fc));
                    chk("done_cqe_cnt", 32'(cqe_cnt), 32'(e.cc));
                    chk("done_stats_cnt", 32'(stats_cnt), 32'(e.sc));
                    chk("done_last_frame_bytes", 32'(last_frame_bytes), 32'(e.lfb));
                end
            end
            if (snap_req) begin
                if (snap_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL snap_queue_empty actual=0 required=1");
                end else begin
                    e = snap_q.pop_front();
                    chk("snap_err_flags", 32'(err_flags), 32'(e.err));
                    chk("snap_frame_cnt", 32'(frame_cnt), 32'(e.fc));
                    chk("snap_cqe_cnt", 32'(cqe_cnt), 32'(e.cc));
                    chk("snap_stats_cnt", 32'(stats_cnt), 32'(e.sc));
                    chk("snap_last_frame_bytes", 32'(last_frame_bytes), 32'(e.lfb));
                    if (e.chk_rdy) chk("snap_tready", 32'(kme_ob_tready), 32'(e.rdy));
                end
            end
        end
    end

    task automatic expect_done(input logic [15:0] fc, input logic [15:0] cc,
                               input logic [15:0] sc, input logic [19:0] lfb);
        exp_t e;
        e = '{err: '0, fc: fc, cc: cc, sc: sc, lfb: lfb, rdy: 1'b0, chk_rdy: 1'b0};
        done_q.push_back(e);
    endtask

    // Called at a falling edge; the monitor samples after the next rising edge.
    task automatic snap(input logic [5:0] err, input logic [15:0] fc, input logic [15:0] cc,
                        input logic [15:0] sc, input logic [19:0] lfb,
                        input logic chk_rdy, input logic rdy);
        exp_t e;
        e = '{err: err, fc: fc, cc: cc, sc: sc, lfb: lfb, rdy: rdy, chk_rdy: chk_rdy};
        snap_q.push_back(e);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    // Presents one beat at a falling edge and holds it until it is accepted.
    task automatic send(input logic [7:0] user, input logic [7:0] data8,
                        input logic [7:0] strb, input logic last);
        int n;
        kme_ob_tvalid = 1'b1;
        kme_ob_tuser  = user;
        kme_ob_tdata  = {56'hA5A5_0000_1234_56, data8};
        kme_ob_tstrb  = strb;
        kme_ob_tlast  = last;
        n = 0;
        while (!kme_ob_tready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_chk++;
            $display("FAIL beat_accept_timeout actual=%0d required=<100", n);
        end
        @(negedge clk);
        kme_ob_tvalid = 1'b0;
        kme_ob_tlast  = 1'b0;
        kme_ob_tuser  = 8'h00;
        kme_ob_tstrb  = 8'h00;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        snap(6'h00, 16'd0, 16'd0, 16'd0, 20'd0, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        snap(6'h00, 16'd0, 16'd0, 16'd0, 20'd0, 1'b1, 1'b1);

        // Nominal CQE frame: 8+8+8+4 bytes
        send(8'h01, 8'h09, 8'hFF, 1'b0);
        send(8'h03, 8'h00, 8'hFF, 1'b0);
        send(8'h03, 8'h00, 8'hFF, 1'b0);
        expect_done(16'd1, 16'd1, 16'd0, 20'd28);
        send(8'h02, 8'h00, 8'h0F, 1'b1);
        snap(6'h00, 16'd1, 16'd1, 16'd0, 20'd28, 1'b1, 1'b1);

        // Stats frame under toggling backpressure: 8+8+2 bytes
        stall_tgl = 1'b1;
        send(8'h01, 8'h08, 8'hFF, 1'b0);
        send(8'h03, 8'h00, 8'hFF, 1'b0);
        expect_done(16'd2, 16'd1, 16'd1, 20'd18);
        send(8'h02, 8'h00, 8'h03, 1'b1);
        stall_tgl = 1'b0;
        repeat (3) @(negedge clk);
        snap(6'h00, 16'd2, 16'd1, 16'd1, 20'd18, 1'b1, 1'b1);

        // Framing errors: MoT in IDLE, SoT, SoT restart, EoT (8+8 bytes)
        send(8'h03, 8'h00, 8'hFF, 1'b0);
        send(8'h01, 8'h00, 8'hFF, 1'b0);
        send(8'h01, 8'h00, 8'hFF, 1'b0);
        expect_done(16'd3, 16'd1, 16'd1, 20'd16);
        send(8'h02, 8'h00, 8'hFF, 1'b1);
        snap(6'h03, 16'd3, 16'd1, 16'd1, 20'd16, 1'b0, 1'b0);

        // Beat errors: EoT strb 0x05 without tlast (8+2 bytes), then illegal tuser
        send(8'h01, 8'h09, 8'hFF, 1'b0);
        expect_done(16'd4, 16'd2, 16'd1, 20'd10);
        send(8'h02, 8'h00, 8'h05, 1'b0);
        send(8'h00, 8'h00, 8'hFF, 1'b0);
        snap(6'h1F, 16'd4, 16'd2, 16'd1, 20'd10, 1'b0, 1'b0);

        // Standalone clear
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        snap(6'h00, 16'd0, 16'd0, 16'd0, 20'd0, 1'b0, 1'b0);

        // Watchdog: one cycle short of the limit, then at the limit
        send(8'h01, 8'h08, 8'hFF, 1'b0);
        repeat (WDOG - 2) @(negedge clk);
        snap(6'h00, 16'd0, 16'd0, 16'd0, 20'd0, 1'b0, 1'b0);
        snap(6'h20, 16'd0, 16'd0, 16'd0, 20'd0, 1'b0, 1'b0);
        send(8'h02, 8'h00, 8'hFF, 1'b1);
        snap(6'h21, 16'd0, 16'd0, 16'd0, 20'd0, 1'b0, 1'b0);

        // clr coincident with an accepted EoT: pulse still fires, counters stay 0
        send(8'h01, 8'h09, 8'hFF, 1'b0);
        expect_done(16'd0, 16'd0, 16'd0, 20'd0);
        clr = 1'b1;
        send(8'h02, 8'h00, 8'h01, 1'b1);
        clr = 1'b0;
        snap(6'h00, 16'd0, 16'd0, 16'd0, 20'd0, 1'b0, 1'b0);
        send(8'h03, 8'h00, 8'hFF, 1'b0);
        snap(6'h01, 16'd0, 16'd0, 16'd0, 20'd0, 1'b0, 1'b0);

        // Reset mid-frame; the following EoT is judged from IDLE
        send(8'h01, 8'h09, 8'hFF, 1'b0);
        send(8'h03, 8'h00, 8'hFF, 1'b0);
        rst = 1'b1;
        snap(6'h00, 16'd0, 16'd0, 16'd0, 20'd0, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        send(8'h02, 8'h00, 8'hFF, 1'b1);
        snap(6'h01, 16'd0, 16'd0, 16'd0, 20'd0, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("pending_done_entries", 32'(done_q.size()), 32'd0);
        chk("pending_snap_entries", 32'(snap_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/kme_ob_frame_monitor.md
KME_OB_FRAME_MONITOR -- requirements
Module: kme_ob_frame_monitor

Interface
REQ-001 Parameter WDOG_LIMIT, default 10000: cycles in frame with no accepted beat before the watchdog fires.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 kme_ob_tvalid  input  1  outbound beat valid.
REQ-005 kme_ob_tdata  input  64  outbound beat data.
REQ-006 kme_ob_tstrb  input  8  byte strobes; bit i marks byte i valid.
REQ-007 kme_ob_tuser  input  8  beat code: 0x01 SoT, 0x02 EoT, 0x03 MoT; any other value is illegal.
REQ-008 kme_ob_tlast  input  1  last beat of frame.
REQ-009 stall  input  1  backpressure request from the sink.
REQ-010 clr  input  1  one-cycle pulse; clears counters and sticky errors.
REQ-011 kme_ob_tready  output  1  registered ready.
REQ-012 frame_cnt, cqe_cnt, stats_cnt  output  16 each  completed frames: all, CQE type, stats type.
REQ-013 last_frame_bytes  output  20  byte count of the most recently completed frame.
REQ-014 frame_done  output  1  one-cycle pulse per completed frame.
REQ-015 err_flags  output  6  sticky: [0] no_sot, [1] sot_in_frame, [2] tlast, [3] tuser, [4] strb, [5] wdog.

Function
REQ-016 Accept: a beat is accepted when kme_ob_tvalid & kme_ob_tready are both 1; unaccepted beats have no effect.
REQ-017 Ready: kme_ob_tready <= ~stall each cycle, so stall reaches kme_ob_tready with 1-cycle latency.
REQ-018 FSM states are IDLE and IN_FRAME.
REQ-019 IDLE + accepted SoT: go to IN_FRAME; latch type from tdata[7:0] (0x09 CQE, 0x08 STATS, else DATA); beat count 1; byte count = popcount(tstrb).
REQ-020 IDLE + accepted MoT or EoT: set err_flags[0]; stay in IDLE; no counter changes.
REQ-021 IN_FRAME + accepted MoT: increment beat count; add popcount(tstrb) to byte count.
REQ-022 IN_FRAME + accepted EoT: add its bytes; go to IDLE; increment frame_cnt and the matching type counter; load last_frame_bytes; pulse frame_done on the next cycle.
REQ-023 IN_FRAME + accepted SoT: set err_flags[1]; abandon the current frame uncounted; restart per REQ-019.
REQ-024 Illegal tuser on an accepted beat: set err_flags[3]; no FSM change; bytes not counted.
REQ-025 tlast check on every accepted legal beat: kme_ob_tlast must equal (tuser==0x02), else set err_flags[2]; framing follows tuser only.
REQ-026 Strobe rule, SoT/MoT beats: tstrb must be 0xFF.
REQ-027 Strobe rule, EoT beats: tstrb must be LSB-contiguous and nonzero (0x01, 0x03, ..., 0xFF).
REQ-028 A strobe violation sets err_flags[4]; the bytes are still counted per popcount.
REQ-029 Watchdog: a counter runs in IN_FRAME on cycles with no accepted beat; it resets to 0 on any accepted beat or in IDLE.
REQ-030 Watchdog expiry: when the counter reaches WDOG_LIMIT, set err_flags[5]; go to IDLE; discard the frame uncounted.
REQ-031 frame_cnt, cqe_cnt and stats_cnt saturate at 0xFFFF.
REQ-032 last_frame_bytes saturates at 0xFFFFF.
REQ-033 clr has priority: counters, last_frame_bytes and err_flags go to 0, and increments or error sets in the same cycle are dropped.
REQ-034 clr does not change FSM, beat count, byte count or watchdog; the FSM still advances on a beat accepted that cycle.

Reset
REQ-035 With rst=1 on an edge:
- FSM to IDLE;
- kme_ob_tready, all counters, last_frame_bytes, frame_done and err_flags to 0;
- watchdog, beat count and byte count to 0.
REQ-036 rst mid-frame discards the partial frame; the first beat after reset is judged from IDLE.

Verification
REQ-037 Nominal frame:
- Stimulus: stall=0; SoT tdata=0x09, 2 MoT, EoT tstrb=0x0F, tlast on EoT only.
- Response: frame_cnt=1, cqe_cnt=1, last_frame_bytes=28, frame_done pulses once, err_flags=0.
REQ-038 Backpressure:
- Stimulus: stats frame (tdata[7:0]=0x08) with stall toggling every cycle.
- Response: beats are accepted only when kme_ob_tready=1; stats_cnt=1; byte count is unaffected by held beats.
REQ-039 Framing errors:
- Stimulus: MoT while IDLE, then SoT, then SoT again, then EoT.
- Response: err_flags[0]=1, err_flags[1]=1, frame_cnt=1.
REQ-040 Beat-level errors:
- Stimulus: EoT with tstrb=0x05 and tlast=0, then a beat with tuser=0x00.
- Response: err_flags[4], err_flags[2] and err_flags[3] set.
REQ-041 Watchdog:
- Stimulus: SoT, then tvalid=0 for WDOG_LIMIT cycles.
- Response: err_flags[5]=1, FSM in IDLE, frame_cnt unchanged; a later EoT sets err_flags[0].
REQ-042 Clear and reset:
- Stimulus: clr in the same cycle as an accepted EoT.
- Response: counters read 0 afterward, FSM in IDLE, frame_done still pulses.
- Stimulus: rst mid-frame.
- Response: all outputs 0.
